// File: rtl/mem_access_stage.sv
// mem_access_stage
//
// Memory-access pipeline stage between EX/MEM and MEM/WB. Non-memory opcodes
// pass straight through with one cycle of latency. Loads and stores run one
// request/acknowledge transaction on the data-memory port. The stage stalls
// upstream until that transaction either completes or times out.
//
// Handshake: MemReq is a level held high from issue until the cycle after
// MemAck (or the timeout). MemWe/MemAddr/MemWData are stable while MemReq=1.
// MemAck is a single-cycle completion pulse, and MemRData is valid only in
// that cycle. Upstream sees Stall as "not ready": EX/MEM must hold its fields
// while Stall=1. Stall drops in the completing/aborting cycle, so each
// instruction is accepted exactly once.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   OpCode/Rd/BranchResult        EX/MEM fields (Rd, BranchResult opaque)
//   ResultAlu                     ALU result, also the memory address
//   StoreData                     store write data
//   MemReq/MemWe/MemAddr/MemWData data-memory request side (registered)
//   MemAck/MemRData               data-memory response side
//   Stall                         combinational hold request to upstream
//   OpCodeOut/RdOut/BranchResultOut/ResultOut  registered MEM/WB fields
//   WbValid                       MEM/WB carries a completed instruction
//   MemErr                        one-cycle pulse on timeout abort
module mem_access_stage #(
  parameter logic [4:0]  OP_LOAD  = 5'd7,
  parameter logic [4:0]  OP_STORE = 5'd11,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  OpCode,
  input  logic [8:0]  Rd,
  input  logic [6:0]  BranchResult,
  input  logic [31:0] ResultAlu,
  input  logic [31:0] StoreData,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        Stall,
  output logic [4:0]  OpCodeOut,
  output logic [8:0]  RdOut,
  output logic [6:0]  BranchResultOut,
  output logic [31:0] ResultOut,
  output logic        WbValid,
  output logic        MemErr
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} stateT;

  // Abort fires on the edge that ends the TIMEOUT-th ACCESS cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  stateT       state, stateNext;
  logic [7:0]  timeoutCnt, timeoutCntNext;
  logic [4:0]  latOpCode, latOpCodeNext;
  logic [8:0]  latRd, latRdNext;
  logic [6:0]  latBranch, latBranchNext;

  logic        memReqNext, memWeNext, wbValidNext, memErrNext;
  logic [31:0] memAddrNext, memWDataNext, resultOutNext;
  logic [4:0]  opCodeOutNext;
  logic [8:0]  rdOutNext;
  logic [6:0]  branchOutNext;

  logic isMem;
  logic abort;

  assign isMem = (OpCode == OP_LOAD) || (OpCode == OP_STORE);
  // MemAck in the abort cycle wins: the transaction completes normally.
  assign abort = (state == ACCESS) && !MemAck && (timeoutCnt == TIMEOUT_LAST);
  assign Stall = ((state == IDLE) && isMem) ||
                 ((state == ACCESS) && !MemAck && !abort);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (isMem) stateNext = ACCESS;
      ACCESS:  if (MemAck || abort) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output / datapath next-value logic. Fields not written hold their value,
  // so MEM/WB fields are only meaningful while WbValid=1.
  always_comb begin
    timeoutCntNext = timeoutCnt;
    latOpCodeNext  = latOpCode;
    latRdNext      = latRd;
    latBranchNext  = latBranch;
    memReqNext     = MemReq;
    memWeNext      = MemWe;
    memAddrNext    = MemAddr;
    memWDataNext   = MemWData;
    opCodeOutNext  = OpCodeOut;
    rdOutNext      = RdOut;
    branchOutNext  = BranchResultOut;
    resultOutNext  = ResultOut;
    wbValidNext    = 1'b0;
    memErrNext     = 1'b0;
    case (state)
      IDLE: begin
        if (isMem) begin
          latOpCodeNext  = OpCode;
          latRdNext      = Rd;
          latBranchNext  = BranchResult;
          memReqNext     = 1'b1;
          memWeNext      = (OpCode == OP_STORE);
          memAddrNext    = ResultAlu;
          memWDataNext   = StoreData;
          timeoutCntNext = 8'd0;
        end else begin
          opCodeOutNext = OpCode;
          rdOutNext     = Rd;
          branchOutNext = BranchResult;
          resultOutNext = ResultAlu;
          wbValidNext   = 1'b1;
        end
      end
      ACCESS: begin
        if (MemAck) begin
          memReqNext     = 1'b0;
          wbValidNext    = 1'b1;
          opCodeOutNext  = latOpCode;
          rdOutNext      = latRd;
          branchOutNext  = latBranch;
          // MemAddr still holds the latched address for stores.
          resultOutNext  = (latOpCode == OP_LOAD) ? MemRData : MemAddr;
          timeoutCntNext = 8'd0;
        end else if (abort) begin
          memReqNext     = 1'b0;
          memErrNext     = 1'b1;
          timeoutCntNext = 8'd0;
        end else begin
          timeoutCntNext = timeoutCnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      timeoutCnt      <= 8'd0;
      latOpCode       <= 5'd0;
      latRd           <= 9'd0;
      latBranch       <= 7'd0;
      MemReq          <= 1'b0;
      MemWe           <= 1'b0;
      MemAddr         <= 32'd0;
      MemWData        <= 32'd0;
      OpCodeOut       <= 5'd0;
      RdOut           <= 9'd0;
      BranchResultOut <= 7'd0;
      ResultOut       <= 32'd0;
      WbValid         <= 1'b0;
      MemErr          <= 1'b0;
    end else begin
      timeoutCnt      <= timeoutCntNext;
      latOpCode       <= latOpCodeNext;
      latRd           <= latRdNext;
      latBranch       <= latBranchNext;
      MemReq          <= memReqNext;
      MemWe           <= memWeNext;
      MemAddr         <= memAddrNext;
      MemWData        <= memWDataNext;
      OpCodeOut       <= opCodeOutNext;
      RdOut           <= rdOutNext;
      BranchResultOut <= branchOutNext;
      ResultOut       <= resultOutNext;
      WbValid         <= wbValidNext;
      MemErr          <= memErrNext;
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage between the EX/MEM pipeline register (`RegEXMEM`) and the MEM/WB register. It consumes the registered `OpCode`, `Rd`, `BranchResult` and `ResultAlu` fields. Load and store opcodes drive a request/acknowledge transaction on the data-memory port, stall the upstream pipeline until the transaction completes, and time out on a hung memory. All other opcodes pass through with one cycle of latency.

## Interface
Parameters:
- `OP_LOAD`, default 5'd7: opcode that performs a data-memory read.
- `OP_STORE`, default 5'd11: opcode that performs a data-memory write.
- `TIMEOUT`, default 15: number of ACCESS cycles without `MemAck` before the transaction is aborted. Legal range is 1..255.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `OpCode` in 5: opcode from EX/MEM.
- `Rd` in 9: destination field from EX/MEM. Opaque to this block.
- `BranchResult` in 7: branch field from EX/MEM. Opaque to this block.
- `ResultAlu` in 32: ALU result. Used as the memory address for loads and stores.
- `StoreData` in 32: write data for stores.
- `MemReq` out 1: memory request, level signal.
- `MemWe` out 1: 1 = write, 0 = read. Valid while `MemReq`=1.
- `MemAddr` out 32: memory address.
- `MemWData` out 32: memory write data.
- `MemAck` in 1: memory completion, one-cycle pulse.
- `MemRData` in 32: read data. Valid in the cycle `MemAck`=1.
- `Stall` out 1: combinational. Upstream holds EX/MEM while this is 1.
- `OpCodeOut` out 5, `RdOut` out 9, `BranchResultOut` out 7: registered to MEM/WB.
- `ResultOut` out 32: registered result to MEM/WB.
- `WbValid` out 1: MEM/WB outputs carry a completed instruction.
- `MemErr` out 1: one-cycle pulse on timeout abort.

## Operation
- FSM has two states: IDLE and ACCESS. Reset forces IDLE and sets the timeout counter to 0.
- Reset values:
  - All registered outputs are 0: `MemReq`, `MemWe`, `MemAddr`, `MemWData`, `OpCodeOut`, `RdOut`, `BranchResultOut`, `ResultOut`, `WbValid`, `MemErr`.
  - `Stall` evaluates combinationally from state and inputs even during reset.
- Define `is_mem` = (`OpCode`==`OP_LOAD`) || (`OpCode`==`OP_STORE`).
- IDLE with non-memory opcode:
  - Register `OpCode`, `Rd` and `BranchResult` to their outputs, `ResultOut` = `ResultAlu`, `WbValid` = 1.
- IDLE with `is_mem`:
  - Latch `OpCode`, `Rd`, `BranchResult` and the address.
  - `MemReq` = 1, `MemWe` = (`OpCode`==`OP_STORE`), `MemAddr` = `ResultAlu`, `MemWData` = `StoreData`.
  - `WbValid` = 0. Go to ACCESS.
- ACCESS with `MemAck`=1:
  - `MemReq` = 0 and `WbValid` = 1, with the latched `OpCode`, `Rd` and `BranchResult` on the outputs.
  - `ResultOut` = `MemRData` for a load, or the latched address for a store.
  - Clear the counter. Go to IDLE.
- ACCESS with `MemAck`=0:
  - Counter increments. `WbValid` = 0 (bubble).
  - When the counter equals `TIMEOUT`−1 at the edge: abort. `MemReq` = 0, `MemErr` = 1 for one cycle, `WbValid` = 0, clear the counter, go to IDLE.
- `MemAck` in the same cycle as the abort condition takes priority: the transaction completes normally.
- `Stall` = (IDLE && `is_mem`) || (ACCESS && !`MemAck` && !abort). It is low in the completing or aborting cycle, so upstream advances exactly once per memory instruction.
- `MemAck` while in IDLE is ignored.
- Inputs from EX/MEM are ignored during ACCESS; upstream holds them anyway.
- The counter width is 8 bits. It never wraps because the abort fires first.

## Timing
- Non-memory instruction: 1-cycle latency, throughput 1 per cycle, `Stall` = 0.
- Memory instruction presented in cycle N:
  - `MemReq` rises at the end of cycle N and is high from cycle N+1.
  - With `MemAck` in cycle N+k (k≥1), `WbValid` = 1 in cycle N+k+1.
  - `Stall` is high in cycles N..N+k−1, giving k cycles of stall.
- `MemAddr`, `MemWe` and `MemWData` stay stable for the entire time `MemReq` = 1.
- Timeout: with no ack, `MemReq` is high in cycles N+1..N+`TIMEOUT`, and `MemErr` = 1 in cycle N+`TIMEOUT`+1.
- Back-to-back memory operations: the second is seen in IDLE the cycle after completion. There is a minimum of 1 cycle with `MemReq` = 0 between requests.
- Reset asserted mid-ACCESS: next cycle is IDLE, `MemReq` = 0, no writeback, no `MemErr`.

## Test plan
- Reset for 2 cycles, then non-memory `OpCode`=3, `Rd`=8, `BranchResult`=1, `ResultAlu`=2 -> next cycle `OpCodeOut`=3, `RdOut`=8, `BranchResultOut`=1, `ResultOut`=2, `WbValid`=1, `Stall` never high.
- Load with `OpCode`=7, `ResultAlu`=0x40, and `MemAck` returned 3 cycles after `MemReq` rises with `MemRData`=0xDEADBEEF:
  - `MemAddr`=0x40 and `MemWe`=0 while requesting.
  - `Stall` high for 3 cycles.
  - Then `ResultOut`=0xDEADBEEF, `WbValid`=1 for exactly 1 cycle.
- Store with `OpCode`=11, `ResultAlu`=0x80, `StoreData`=9, immediate ack (k=1):
  - `MemWe`=1, `MemWData`=9.
  - `Stall` high for 1 cycle.
  - Then `ResultOut`=0x80, `WbValid`=1.
- Load followed by non-memory `OpCode`=5 held upstream until `Stall` falls:
  - Exactly one memory request is issued.
  - The op-5 writeback follows the load writeback by exactly 1 cycle.
- No ack with `TIMEOUT`=4 -> `MemReq` high for 4 cycles, `MemErr`=1 for 1 cycle, `WbValid` stays 0, `Stall` falls in the abort cycle.
- `rst`=1 in the second ACCESS cycle -> next cycle all outputs are 0 and the FSM is in IDLE. A subsequent load completes normally.
